// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op and state encodings shared by the multiply/divide unit and the controller decode
package mul_div_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// mdu_sign_fix: operand magnitude extraction at launch and result sign restoration at the end
module mdu_sign_fix
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               launch_signed,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               neg_res,
    output logic               neg_rem,
    output logic               div_zero,
    input  logic               fix_is_div,
    input  logic               fix_neg_res,
    input  logic               fix_neg_rem,
    input  logic               fix_div_zero,
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   quo,
    input  logic [WIDTH-1:0]   rem,
    output logic [WIDTH-1:0]   fix_hi,
    output logic [WIDTH-1:0]   fix_lo
);

    logic               sa;
    logic               sb;
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quo_f;
    logic [WIDTH-1:0]   rem_f;

    // Strip operand signs so the iterative core only ever sees magnitudes
    always_comb begin
        sa       = launch_signed & rs[WIDTH-1];
        sb       = launch_signed & rt[WIDTH-1];
        mag_a    = sa ? -rs : rs;
        mag_b    = sb ? -rt : rt;
        neg_res  = sa ^ sb;
        neg_rem  = sa;
        div_zero = (rt == '0);
    end

    // Restore signs; the remainder follows the dividend, a zero divisor forces an all-ones quotient
    always_comb begin
        prod_f = fix_neg_res ? -prod : prod;
        quo_f  = fix_div_zero ? '1 : (fix_neg_res ? -quo : quo);
        rem_f  = fix_neg_rem ? -rem : rem;
        fix_hi = fix_is_div ? rem_f : prod_f[2*WIDTH-1:WIDTH];
        fix_lo = fix_is_div ? quo_f : prod_f[WIDTH-1:0];
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle shift-add multiplier and restoring divider producing HI/LO
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_q, div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               launch;
    logic               last;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               neg_res, neg_rem, div_zero;
    logic [WIDTH:0]     trial;
    logic [WIDTH+1:0]   diff;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .launch_signed (is_signed_op(op)),
        .rs            (rsData),
        .rt            (rtData),
        .mag_a         (mag_a),
        .mag_b         (mag_b),
        .neg_res       (neg_res),
        .neg_rem       (neg_rem),
        .div_zero      (div_zero),
        .fix_is_div    (div_q),
        .fix_neg_res   (neg_res_q),
        .fix_neg_rem   (neg_rem_q),
        .fix_div_zero  (dz_q),
        .prod          (acc_q),
        .quo           (b_q),
        .rem           (acc_q[WIDTH-1:0]),
        .fix_hi        (fix_hi),
        .fix_lo        (fix_lo)
    );

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Launch is accepted only when no operation is in flight
    always_comb begin
        launch = start & (state_q == S_IDLE || state_q == S_DONE);
        last   = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_CALC : S_IDLE;
            S_CALC:  state_d = last ? S_FIX : S_CALC;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = start ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; hi/lo come straight from their registers
    always_comb begin
        busy = (state_q == S_CALC) || (state_q == S_FIX);
        done = (state_q == S_DONE);
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath: a holds the (shifting) multiplicand or the divisor, b the multiplier or dividend/quotient
    always_comb begin
        trial     = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
        diff      = {1'b0, trial} - {2'b00, a_q[WIDTH-1:0]};
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (launch) begin
            cnt_d     = '0;
            acc_d     = '0;
            a_d       = (2*WIDTH)'(mag_b);
            b_d       = mag_a;
            div_d     = is_div_op(op);
            neg_res_d = neg_res;
            neg_rem_d = neg_rem;
            dz_d      = div_zero;
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                acc_d = (2*WIDTH)'(diff[WIDTH+1] ? trial : diff[WIDTH:0]);
                b_d   = {b_q[WIDTH-2:0], ~diff[WIDTH+1]};
            end else begin
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
            end
        end else if (state_q == S_FIX) begin
            hi_d = fix_hi;
            lo_d = fix_lo;
        end
    end

    // Datapath and result registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: vector table, corner sequences and randomized ops against an arithmetic model
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rsData = '0;
    logic [31:0] rtData = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    mul_div_unit dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rsData (rsData),
        .rtData (rtData),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (o == OP_MULT) res = sa * sb;
        else if (o == OP_MULTU) res = ua * ub;
        else if (b == 0) res = {a, 32'hFFFF_FFFF};
        else if (o == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end else res = {32'(ua % ub), 32'(ua / ub)};
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Launch one op, scramble inputs while it runs, report result, latency and whether hi/lo held
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output int cyc, output bit held);
        logic [31:0] ph, pl;
        @(negedge CLK);
        ph = hi; pl = lo;
        op = o; rsData = a; rtData = b; start = 1'b1;
        held = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            if (hi !== ph || lo !== pl) held = 1'b0;
            rsData = $urandom; rtData = $urandom; op = 2'($urandom);
            @(negedge CLK);
            cyc++;
        end
        rh = hi; rl = lo;
    endtask

    initial begin
        logic [31:0] rh, rl;
        logic [1:0]  o;
        logic [31:0] a, b;
        int          cyc;
        bit          held;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{OP_DIV,   32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{OP_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        vecs[8]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9]  = '{OP_MULT,  32'd5,         32'd6,         32'h0000_0000, 32'h0000_001E};
        vecs[10] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};

        repeat (2) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        reset = 1'b1;
        @(negedge CLK);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, cyc, held);
            chk($sformatf("vec%0d_hilo", i), {rh, rl}, {vecs[i].hi, vecs[i].lo});
            chk($sformatf("vec%0d_lat", i), cyc, 34);
            chk($sformatf("vec%0d_hold", i), held, 1);
        end

        @(negedge CLK);
        op = OP_MULTU; rsData = '1; rtData = '1; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cyc = 1;
        chk("seq_busy", busy, 1);
        while (!done && cyc < 100) begin
            if (cyc == 10) begin
                start = 1'b1; op = OP_DIV; rsData = 32'd3; rtData = 32'd0;
            end else if (cyc == 11) start = 1'b0;
            else if (cyc == 32) begin
                start = 1'b1; op = OP_MULT; rsData = 32'd5; rtData = 32'd6;
            end
            @(negedge CLK);
            cyc++;
        end
        chk("ign_lat", cyc, 34);
        chk("ign_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge CLK);
        chk("b2b_busy", busy, 1);
        chk("b2b_done", done, 0);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        chk("b2b_lat", cyc, 34);
        chk("b2b_hilo", {hi, lo}, 64'd30);

        @(negedge CLK);
        op = OP_DIV; rsData = 32'd1000; rtData = 32'd7; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (14) @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_hilo", {hi, lo}, 64'h0);
        @(negedge CLK);
        reset = 1'b1;
        run_op(OP_MULT, 32'd5, 32'd6, rh, rl, cyc, held);
        chk("post_rst_hilo", {rh, rl}, 64'd30);
        chk("post_rst_lat", cyc, 34);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = pick();
            b = pick();
            run_op(o, a, b, rh, rl, cyc, held);
            chk($sformatf("rand%0d_op%0d_%h_%h", i, o, a, b), {rh, rl}, model(o, a, b));
            chk($sformatf("rand%0d_lat", i), cyc, 34);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
